pulse_peak_finder: RTL

Downstream consumer of the shaping filter's output stream. Watches the per-clock filtered samples, detects pulses that cross a programmable threshold, and tracks each pulse's maximum. For every pulse it emits one event record holding peak amplitude, peak timestamp and pulse width, through a valid/ready handshake to the readout logic. A programmable hold-off suppresses re-triggering on the pulse tail.

---
 rtl/pulse_pkg.sv | 22 ++
 rtl/pulse_peak_finder_evt_out_reg.sv | 57 +++++
 rtl/pulse_peak_finder.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/pulse_pkg.sv
// Shared types and default widths for the pulse peak finder and its upstream shaping filter.
package pulse_pkg;

    localparam int DEF_SIZE_FILTER_DATA = 16;
    localparam int DEF_TS_WIDTH         = 32;
    localparam int DEF_WIDTH_BITS       = 8;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_HOLDOFF = 2'd2
    } state_e;

    // "time" is a keyword, so the timestamp field is named ts.
    typedef struct packed {
        logic signed [DEF_SIZE_FILTER_DATA-1:0] amp;
        logic [DEF_TS_WIDTH-1:0]                ts;
        logic [DEF_WIDTH_BITS-1:0]              width;
        logic                                   pileup;
    } evt_rec_t;

endpackage

// File: rtl/pulse_peak_finder_evt_out_reg.sv
// One-deep valid/ready holding register for event records, with a saturating drop counter.
module evt_out_reg #(
    parameter type rec_t     = pulse_pkg::evt_rec_t,
    parameter int  DROP_BITS = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 load_i,
    input  rec_t                 rec_i,
    input  logic                 ready_i,
    output logic                 valid_o,
    output rec_t                 rec_o,
    output logic [DROP_BITS-1:0] drop_cnt_o
);

    logic                 valid_q, valid_d;
    rec_t                 rec_q, rec_d;
    logic [DROP_BITS-1:0] drop_q, drop_d;
    logic                 take;

    // A new record may replace the held one in the same cycle it is accepted.
    assign take = load_i && (!valid_q || ready_i);

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        valid_d = valid_q;
        rec_d   = rec_q;
        drop_d  = drop_q;
        if (take) begin
            valid_d = 1'b1;
            rec_d   = rec_i;
        end else if (valid_q && ready_i) begin
            valid_d = 1'b0;
        end
        if (load_i && !take && drop_q != '1) begin
            drop_d = drop_q + 1'b1;
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_q <= 1'b0;
            rec_q   <= '0;
            drop_q  <= '0;
        end else begin
            valid_q <= valid_d;
            rec_q   <= rec_d;
            drop_q  <= drop_d;
        end
    end

    assign valid_o    = valid_q;
    assign rec_o      = rec_q;
    assign drop_cnt_o = drop_q;

endmodule

// File: rtl/pulse_peak_finder.sv
// Threshold pulse detector emitting {peak, peak time, width} per pulse with hold-off.
// Define PEAK_PILEUP_EN to build the pile-up detector; otherwise evt_pileup stays 0.
module pulse_peak_finder #(
    parameter int SIZE_FILTER_DATA = pulse_pkg::DEF_SIZE_FILTER_DATA,
    parameter int TS_WIDTH         = pulse_pkg::DEF_TS_WIDTH,
    parameter int WIDTH_BITS       = pulse_pkg::DEF_WIDTH_BITS,
    parameter int DROP_BITS        = 16
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic signed [SIZE_FILTER_DATA-1:0] filter_data,
    input  logic signed [SIZE_FILTER_DATA-1:0] threshold,
    input  logic [7:0]                         holdoff_len,
    output logic                               evt_valid,
    input  logic                               evt_ready,
    output logic signed [SIZE_FILTER_DATA-1:0] evt_amp,
    output logic [TS_WIDTH-1:0]                evt_time,
    output logic [WIDTH_BITS-1:0]              evt_width,
    output logic                               evt_pileup,
    output logic [DROP_BITS-1:0]               drop_cnt
);
    import pulse_pkg::*;

    typedef struct packed {
        logic signed [SIZE_FILTER_DATA-1:0] amp;
        logic [TS_WIDTH-1:0]                ts;
        logic [WIDTH_BITS-1:0]              width;
        logic                               pileup;
    } evt_t;

    state_e                             state_q, state_d;
    logic signed [SIZE_FILTER_DATA-1:0] s_reg_q, max_q, max_d;
    logic [TS_WIDTH-1:0]                ts_q, s_ts_q, t_max_q, t_max_d;
    logic [WIDTH_BITS-1:0]              wcnt_q, wcnt_d;
    logic [7:0]                         hcnt_q, hcnt_d;
    logic                               above, evt_done, pile_w;
    evt_t                               rec_in, rec_out;

    assign above = s_reg_q > threshold;

    always_comb begin
        state_d  = state_q;
        max_d    = max_q;
        t_max_d  = t_max_q;
        wcnt_d   = wcnt_q;
        hcnt_d   = hcnt_q;
        evt_done = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (above) begin
                    state_d = ST_ARMED;
                    max_d   = s_reg_q;
                    t_max_d = s_ts_q;
                    wcnt_d  = WIDTH_BITS'(1);
                end
            end
            ST_ARMED: begin
                if (above) begin
                    if (wcnt_q != '1) wcnt_d = wcnt_q + 1'b1;
                    // Strict compare keeps the first sample of a plateau.
                    if (s_reg_q > max_q) begin
                        max_d   = s_reg_q;
                        t_max_d = s_ts_q;
                    end
                end else begin
                    evt_done = 1'b1;
                    state_d  = ST_HOLDOFF;
                    hcnt_d   = holdoff_len;
                end
            end
            ST_HOLDOFF: begin
                if (hcnt_q != 8'd0) hcnt_d = hcnt_q - 1'b1;
                if (hcnt_q == 8'd0 && !above) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            ts_q    <= '0;
            s_reg_q <= '0;
            s_ts_q  <= '0;
            max_q   <= '0;
            t_max_q <= '0;
            wcnt_q  <= '0;
            hcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            ts_q    <= ts_q + 1'b1;
            s_reg_q <= filter_data;
            s_ts_q  <= ts_q;
            max_q   <= max_d;
            t_max_q <= t_max_d;
            wcnt_q  <= wcnt_d;
            hcnt_q  <= hcnt_d;
        end
    end

`ifdef PEAK_PILEUP_EN
    logic                             prev_above_q, pend_q, pend_d, fell_q, fell_d, lmax_q, lmax_d;
    logic signed [SIZE_FILTER_DATA:0] fall_amt, half_thr;

    // One extra bit so max - sample cannot overflow.
    assign fall_amt = {max_q[SIZE_FILTER_DATA-1], max_q} - {s_reg_q[SIZE_FILTER_DATA-1], s_reg_q};
    assign half_thr = {threshold[SIZE_FILTER_DATA-1], threshold >>> 1};

    always_comb begin
        pend_d = pend_q;
        fell_d = fell_q;
        lmax_d = lmax_q;
        case (state_q)
            ST_IDLE: begin
                if (above) begin
                    fell_d = 1'b0;
                    lmax_d = 1'b0;
                end
            end
            ST_ARMED: begin
                if (above) begin
                    if (s_reg_q > max_q) begin
                        if (fell_q) lmax_d = 1'b1;
                        fell_d = 1'b0;
                    end else if (fall_amt >= half_thr) begin
                        fell_d = 1'b1;
                    end
                end else begin
                    pend_d = 1'b0;
                end
            end
            ST_HOLDOFF: begin
                if (hcnt_q != 8'd0 && above && !prev_above_q) pend_d = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prev_above_q <= 1'b0;
            pend_q       <= 1'b0;
            fell_q       <= 1'b0;
            lmax_q       <= 1'b0;
        end else begin
            prev_above_q <= above;
            pend_q       <= pend_d;
            fell_q       <= fell_d;
            lmax_q       <= lmax_d;
        end
    end

    assign pile_w = pend_q | lmax_q;
`else
    assign pile_w = 1'b0;
`endif

    assign rec_in = '{amp: max_q, ts: t_max_q, width: wcnt_q, pileup: pile_w};

    evt_out_reg #(
        .rec_t     (evt_t),
        .DROP_BITS (DROP_BITS)
    ) u_evt_out_reg (
        .clk        (clk),
        .reset      (reset),
        .load_i     (evt_done),
        .rec_i      (rec_in),
        .ready_i    (evt_ready),
        .valid_o    (evt_valid),
        .rec_o      (rec_out),
        .drop_cnt_o (drop_cnt)
    );

    assign evt_amp    = rec_out.amp;
    assign evt_time   = rec_out.ts;
    assign evt_width  = rec_out.width;
    assign evt_pileup = rec_out.pileup;

endmodule
